// File: rtl/sl_pkg.sv
// SL link shared types and helpers.
// Word-size encoding and receiver state names.
package sl_pkg;

  typedef enum logic [1:0] {
    SL_MODE_8  = 2'b00,
    SL_MODE_16 = 2'b01,
    SL_MODE_32 = 2'b10
  } sl_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RECV = 2'b01,
    ST_DONE = 2'b10
  } sl_rx_state_t;

  // Data bits per word; the unused encoding 11 also means 32.
  function automatic logic [5:0] sl_word_bits(input logic [1:0] i_mode);
    logic [5:0] w_bits;
    case (i_mode)
      SL_MODE_8:  w_bits = 6'd8;
      SL_MODE_16: w_bits = 6'd16;
      default:    w_bits = 6'd32;
    endcase
    return w_bits;
  endfunction

endpackage

// File: rtl/sl_line_sync.sv
// Two-line 2-flop synchronizer with registered rising-edge detect.
// o_lvl and o_rise are aligned to the same cycle.
module sl_line_sync (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_d,
  output logic [1:0] o_lvl,
  output logic [1:0] o_rise
);

  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_lvl;
  logic [1:0] r_rise;

  // Synchronize, then register level and its rising edge together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 2'b00;
      r_s2   <= 2'b00;
      r_lvl  <= 2'b00;
      r_rise <= 2'b00;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_lvl  <= r_s2;
      r_rise <= r_s2 & ~r_lvl;
    end
  end

  assign o_lvl  = r_lvl;
  assign o_rise = r_rise;

endmodule

// File: rtl/sl_receiver.sv
// SL word receiver: decodes SL0/SL1 pulses into 8/16/32-bit words.
// Checks odd parity, bit count and both-lines-high framing.
module sl_receiver #(
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sl0,
  input  logic        sl1,
  input  logic [1:0]  mode,
  output logic [31:0] data,
  output logic        ready,
  output logic        valid,
  output logic        len_err,
  output logic        line_err,
  output logic        busy
);
  import sl_pkg::*;

  sl_rx_state_t r_state;
  sl_rx_state_t w_next;

  logic [1:0]  w_lvl;
  logic [1:0]  w_rise;
  logic        w_start;
  logic        w_finish;
  logic        w_bit_ok;
  logic        w_bit;
  logic        w_both;
  logic        w_low;
  logic        w_gap_hit;
  logic [5:0]  w_bits;
  logic        w_len_bad;
  logic [31:0] w_mask;

  logic [1:0]  r_mode;
  logic [31:0] r_sh;
  logic [5:0]  r_cnt;
  logic [7:0]  r_gap;
  logic        r_par;
  logic        r_lerr;
  logic [31:0] r_data;
  logic        r_ready;
  logic        r_valid;
  logic        r_len_err;
  logic        r_line_err;
  logic        r_busy;

  sl_line_sync u_sync (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_d    ({sl1, sl0}),
    .o_lvl  (w_lvl),
    .o_rise (w_rise)
  );

  // A bit counts only when exactly one line rises and the
  // lines are not both high in that cycle.
  assign w_both    = &w_lvl;
  assign w_low     = ~|w_lvl;
  assign w_bit     = w_rise[1];
  assign w_bit_ok  = (w_rise[0] ^ w_rise[1]) & ~w_both;
  assign w_gap_hit = w_low && (r_gap == 8'(GAP_CYCLES - 1));

  assign w_bits    = sl_word_bits(r_mode);
  assign w_len_bad = (r_cnt != (w_bits + 6'd1));
  assign w_mask    = ~(32'hFFFF_FFFF >> w_bits);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; the final gap cycle closes the word.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_finish = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_rise) begin
          w_start = 1'b1;
          w_next  = ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_gap_hit) begin
          w_finish = 1'b1;
          w_next   = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Shift, count, gap and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode     <= 2'b00;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_par      <= 1'b0;
      r_lerr     <= 1'b0;
      r_data     <= '0;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_len_err  <= 1'b0;
      r_line_err <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_start) begin
      r_mode     <= mode;
      r_sh       <= w_bit_ok ? {w_bit, 31'b0} : 32'b0;
      r_cnt      <= {5'b0, w_bit_ok};
      r_par      <= w_bit_ok & w_bit;
      r_gap      <= '0;
      r_lerr     <= w_both;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_len_err  <= 1'b0;
      r_line_err <= 1'b0;
      r_busy     <= 1'b1;
    end else if (r_state == ST_RECV) begin
      if (w_bit_ok) begin
        if (r_cnt < 6'd32) begin
          r_sh <= r_sh | ({w_bit, 31'b0} >> r_cnt);
        end
        if (r_cnt != 6'd63) begin
          r_cnt <= r_cnt + 6'd1;
        end
        r_par <= r_par ^ w_bit;
      end
      if (w_both) begin
        r_lerr <= 1'b1;
      end
      r_gap <= w_low ? r_gap + 8'd1 : 8'd0;
      if (w_finish) begin
        r_data     <= r_sh & w_mask;
        r_ready    <= 1'b1;
        r_busy     <= 1'b0;
        r_len_err  <= w_len_bad;
        r_line_err <= r_lerr;
        r_valid    <= r_par & ~w_len_bad & ~r_lerr;
      end
    end
  end

  assign data     = r_data;
  assign ready    = r_ready;
  assign valid    = r_valid;
  assign len_err  = r_len_err;
  assign line_err = r_line_err;
  assign busy     = r_busy;

endmodule

// File: tb/tb_sl_receiver.sv
// Bench for sl_receiver: directed and random words
// against a word-level reference model.
module tb_sl_receiver;

  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        sl0;
  logic        sl1;
  logic [1:0]  mode;
  logic [31:0] data;
  logic        ready;
  logic        valid;
  logic        len_err;
  logic        line_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int since    = 0;
  bit chk_start = 1'b0;
  bit rdy_model = 1'b0;
  bit exp_rdy   = 1'b0;

  sl_receiver #(.GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .sl0      (sl0),
    .sl1      (sl1),
    .mode     (mode),
    .data     (data),
    .ready    (ready),
    .valid    (valid),
    .len_err  (len_err),
    .line_err (line_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; start-latency checks keyed to cycles since first raw rise.
  task automatic tick();
    @(posedge clk);
    #1;
    since++;
    if (chk_start && since == 3) begin
      check("pre_start_busy", 32'(busy), 32'd0);
      check("pre_start_ready", 32'(ready), 32'(exp_rdy));
    end
    if (chk_start && since == 4) begin
      check("start_busy", 32'(busy), 32'd1);
      check("start_ready", 32'(ready), 32'd0);
      check("start_valid", 32'(valid), 32'd0);
    end
  endtask

  // Events: 0 = pulse on sl0, 1 = pulse on sl1, 2 = both together.
  function automatic void model(input logic [1:0] m, input int ev[$],
                                output logic [31:0] d, output logic v,
                                output logic le, output logic ln);
    int n;
    int cnt;
    bit par;
    n   = (m == 2'd0) ? 8 : (m == 2'd1) ? 16 : 32;
    cnt = 0;
    par = 1'b0;
    d   = '0;
    ln  = 1'b0;
    foreach (ev[i]) begin
      if (ev[i] == 2) begin
        ln = 1'b1;
      end else begin
        if (cnt < n) d[31 - cnt] = (ev[i] == 1);
        cnt++;
        par = par ^ (ev[i] == 1);
      end
    end
    if (cnt > 63) cnt = 63;
    le = (cnt != n + 1);
    v  = par && !le && !ln;
  endfunction

  // pm: 0 good parity, 1 inverted, 2 none, 3 good parity plus extra bit.
  function automatic void build(input logic [31:0] val, input int nd,
                                input int pm, output int q[$]);
    bit p;
    int b;
    p = 1'b1;
    q = {};
    for (int i = 0; i < nd; i++) begin
      b = val[nd - 1 - i] ? 1 : 0;
      q.push_back(b);
      p = p ^ (b == 1);
    end
    if (pm == 0 || pm == 3) q.push_back(p ? 1 : 0);
    if (pm == 1) q.push_back(p ? 0 : 1);
    if (pm == 3) q.push_back(int'($urandom_range(0, 1)));
  endfunction

  task automatic send(input logic [1:0] m, input int ev[$],
                      input bit chg, input bit complete);
    logic [31:0] ed;
    logic        evld;
    logic        elen;
    logic        eln;
    mode      = m;
    since     = 0;
    exp_rdy   = rdy_model;
    chk_start = 1'b1;
    foreach (ev[i]) begin
      sl0 = (ev[i] == 0) || (ev[i] == 2);
      sl1 = (ev[i] == 1) || (ev[i] == 2);
      repeat ($urandom_range(1, 3)) tick();
      sl0 = 1'b0;
      sl1 = 1'b0;
      if (chg && i == 2) mode = 2'($urandom_range(0, 3));
      if (i != ev.size() - 1) repeat ($urandom_range(1, 4)) tick();
    end
    if (complete) begin
      model(m, ev, ed, evld, elen, eln);
      repeat (GAP + 2) tick();
      check("ready_early", 32'(ready), 32'd0);
      check("busy_hold", 32'(busy), 32'd1);
      tick();
      check("ready_done", 32'(ready), 32'd1);
      check("busy_done", 32'(busy), 32'd0);
      check("data", data, ed);
      check("valid", 32'(valid), 32'(evld));
      check("len_err", 32'(len_err), 32'(elen));
      check("line_err", 32'(line_err), 32'(eln));
      rdy_model = 1'b1;
    end
    chk_start = 1'b0;
  endtask

  initial begin
    int q[$];
    logic [1:0] m;
    int n;
    int nd;
    int pm;

    reset = 1'b1;
    sl0   = 1'b0;
    sl1   = 1'b0;
    mode  = 2'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_data", data, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_len", 32'(len_err), 32'd0);
    check("rst_line", 32'(line_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    build(32'hA5, 8, 0, q);
    send(2'd0, q, 1'b0, 1'b1);
    check("a5_data", data, 32'hA500_0000);
    check("a5_valid", 32'(valid), 32'd1);
    repeat (5) tick();

    build(32'hDEADBEEF, 32, 0, q);
    send(2'd2, q, 1'b1, 1'b1);
    check("dead_data", data, 32'hDEADBEEF);
    build(32'hDEADBEEF, 32, 1, q);
    send(2'd2, q, 1'b0, 1'b1);
    check("dead_bad_valid", 32'(valid), 32'd0);
    repeat (3) tick();

    build(32'h1234, 16, 2, q);
    send(2'd1, q, 1'b0, 1'b1);
    check("short_len", 32'(len_err), 32'd1);
    repeat (4) tick();

    build(32'h5A, 8, 0, q);
    q.insert(4, 2);
    send(2'd0, q, 1'b0, 1'b1);
    check("line_flag", 32'(line_err), 32'd1);

    build(32'h3C, 8, 0, q);
    send(2'd0, q, 1'b0, 1'b1);
    check("b2b_first", data, 32'h3C00_0000);
    build(32'hC3, 8, 0, q);
    send(2'd0, q, 1'b0, 1'b1);
    check("b2b_second", data, 32'hC300_0000);
    repeat (2) tick();

    build(32'h1F, 5, 2, q);
    send(2'd0, q, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rdy_model = 1'b0;
    check("mid_rst_data", data, 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_len", 32'(len_err), 32'd0);
    check("mid_rst_line", 32'(line_err), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    build(32'h81, 8, 0, q);
    send(2'd0, q, 1'b0, 1'b1);
    check("x81_data", data, 32'h8100_0000);
    check("x81_valid", 32'(valid), 32'd1);

    q = {};
    for (int i = 0; i < 70; i++) q.push_back(int'($urandom_range(0, 1)));
    send(2'd0, q, 1'b0, 1'b1);

    for (int k = 0; k < 24; k++) begin
      m  = 2'($urandom_range(0, 3));
      n  = (m == 2'd0) ? 8 : (m == 2'd1) ? 16 : 32;
      nd = ($urandom_range(0, 3) == 0) ? n - int'($urandom_range(1, 3)) : n;
      pm = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
      build($urandom, nd, pm, q);
      if ($urandom_range(0, 5) == 0) q.insert(int'($urandom_range(2, 4)), 2);
      send(m, q, 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
